// File: rtl/chnl_rx_frame_source.sv
// On-chip far end of the RIFFA RX channel: streams one decode frame (config word, then payload words
// read from a 1-cycle-latency source RAM) through a 2-entry prefetch buffer.
module chnl_rx_frame_source #(
  parameter int DATA_W = 128,
  parameter int ADDR_W = 15,
  parameter int CB_W   = 5
) (
  input  logic              clk_pcie,
  input  logic              RST,
  input  logic              start,
  input  logic [12:0]       code_length,
  input  logic [3:0]        iter_max,
  input  logic [31:0]       sys_words,
  input  logic [31:0]       tx_words,
  input  logic [CB_W-1:0]   cb_num,
  output logic              busy,
  output logic              done,
  output logic              src_rd,
  output logic [ADDR_W-1:0] src_addr,
  input  logic [DATA_W-1:0] src_data,
  output logic              CHNL_RX,
  input  logic              CHNL_RX_ACK,
  output logic              CHNL_RX_LAST,
  output logic [31:0]       CHNL_RX_LEN,
  output logic [30:0]       CHNL_RX_OFF,
  output logic [DATA_W-1:0] CHNL_RX_DATA,
  output logic              CHNL_RX_DATA_VALID,
  input  logic              CHNL_RX_DATA_REN
);

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_STREAM, S_FINISH} state_t;

  state_t              r_state;
  state_t              w_state_next;
  logic [31:0]         r_w;
  logic [31:0]         r_len;
  logic [31:0]         r_sent;
  logic [31:0]         r_issued;
  logic [ADDR_W-1:0]   r_src_addr;
  logic                r_rd_pend;
  logic [DATA_W-1:0]   r_buf [0:1];
  logic                r_head;
  logic [1:0]          r_occ;

  logic                w_start_ok;
  logic                w_valid;
  logic                w_pop;
  logic                w_push;
  logic                w_tail;
  logic [2:0]          w_level;
  logic [31:0]         w_cb;
  logic [31:0]         w_t;
  logic [31:0]         w_w;
  logic [DATA_W-1:0]   w_cfg;

  assign w_cb  = {{(32-CB_W){1'b0}}, cb_num};
  assign w_t   = (w_cb << 2) + (w_cb << 1) + 32'd6;
  assign w_w   = 32'd1 + (sys_words << 1) + w_t;
  assign w_cfg = {tx_words, sys_words, 28'd0, iter_max, 19'd0, code_length};

  assign w_start_ok = (r_state == S_IDLE) && start && (sys_words != 32'd0);
  assign w_valid    = (r_state == S_STREAM) && (r_occ != 2'd0);
  assign w_pop      = w_valid && CHNL_RX_DATA_REN;
  assign w_push     = r_rd_pend;
  // Tail slot is head+occupancy; at occupancy 2 with a pop this is the slot being vacated.
  assign w_tail     = r_head ^ r_occ[0];
  // Reads in flight are counted against the buffer, crediting this cycle's pop to avoid bubbles.
  assign w_level    = {1'b0, r_occ} + {2'b00, r_rd_pend} - {2'b00, w_pop};
  assign src_rd     = ((r_state == S_REQ) || (r_state == S_STREAM)) &&
                      (w_level < 3'd2) && (r_issued < r_w - 32'd1);

  assign src_addr           = r_src_addr;
  assign CHNL_RX_LEN        = r_len;
  assign CHNL_RX_DATA       = r_buf[r_head];
  assign CHNL_RX_DATA_VALID = w_valid;
  assign CHNL_RX_LAST       = 1'b1;
  assign CHNL_RX_OFF        = 31'd0;

  always_ff @(posedge clk_pcie) begin
    if (RST) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    busy         = 1'b0;
    done         = 1'b0;
    CHNL_RX      = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_start_ok) w_state_next = S_REQ;
      end
      S_REQ: begin
        busy    = 1'b1;
        CHNL_RX = 1'b1;
        if (CHNL_RX_ACK) w_state_next = S_STREAM;
      end
      S_STREAM: begin
        busy    = 1'b1;
        CHNL_RX = 1'b1;
        if (w_pop && (r_sent == r_w - 32'd1)) w_state_next = S_FINISH;
      end
      S_FINISH: begin
        done         = 1'b1;
        w_state_next = S_IDLE;
      end
      default: w_state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_pcie) begin
    if (RST) begin
      r_w        <= 32'd0;
      r_len      <= 32'd0;
      r_sent     <= 32'd0;
      r_issued   <= 32'd0;
      r_src_addr <= '0;
      r_rd_pend  <= 1'b0;
      r_head     <= 1'b0;
      r_occ      <= 2'd0;
      r_buf[0]   <= '0;
      r_buf[1]   <= '0;
    end else begin
      r_rd_pend <= src_rd;
      if (w_start_ok) begin
        r_w        <= w_w;
        r_len      <= w_w << 2;
        r_sent     <= 32'd0;
        r_issued   <= 32'd0;
        r_src_addr <= '0;
        r_buf[0]   <= w_cfg;
        r_head     <= 1'b0;
        r_occ      <= 2'd1;
      end else begin
        if (src_rd) begin
          r_issued <= r_issued + 32'd1;
          // Address parks on the last payload word rather than running past it.
          if (r_issued + 32'd1 < r_w - 32'd1) r_src_addr <= r_src_addr + 1'b1;
        end
        if (w_pop) begin
          r_sent <= r_sent + 32'd1;
          r_head <= ~r_head;
        end
        if (w_push) r_buf[w_tail] <= src_data;
        r_occ <= r_occ - {1'b0, w_pop} + {1'b0, w_push};
      end
    end
  end

endmodule

// File: tb/tb_chnl_rx_frame_source.sv
// Directed bench for chnl_rx_frame_source: models the source RAM and the RIFFA receiver side.
module tb_chnl_rx_frame_source;
  localparam int DATA_W = 128;
  localparam int ADDR_W = 15;
  localparam int CB_W   = 5;

  logic              clk_pcie = 1'b0;
  logic              RST;
  logic              start;
  logic [12:0]       code_length;
  logic [3:0]        iter_max;
  logic [31:0]       sys_words;
  logic [31:0]       tx_words;
  logic [CB_W-1:0]   cb_num;
  logic              busy, done, src_rd;
  logic [ADDR_W-1:0] src_addr;
  logic [DATA_W-1:0] src_data;
  logic              CHNL_RX, CHNL_RX_ACK, CHNL_RX_LAST;
  logic [31:0]       CHNL_RX_LEN;
  logic [30:0]       CHNL_RX_OFF;
  logic [DATA_W-1:0] CHNL_RX_DATA;
  logic              CHNL_RX_DATA_VALID, CHNL_RX_DATA_REN;

  always #5 clk_pcie = ~clk_pcie;

  chnl_rx_frame_source #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .CB_W(CB_W)) dut (
    .clk_pcie(clk_pcie), .RST(RST), .start(start), .code_length(code_length),
    .iter_max(iter_max), .sys_words(sys_words), .tx_words(tx_words), .cb_num(cb_num),
    .busy(busy), .done(done), .src_rd(src_rd), .src_addr(src_addr), .src_data(src_data),
    .CHNL_RX(CHNL_RX), .CHNL_RX_ACK(CHNL_RX_ACK), .CHNL_RX_LAST(CHNL_RX_LAST),
    .CHNL_RX_LEN(CHNL_RX_LEN), .CHNL_RX_OFF(CHNL_RX_OFF), .CHNL_RX_DATA(CHNL_RX_DATA),
    .CHNL_RX_DATA_VALID(CHNL_RX_DATA_VALID), .CHNL_RX_DATA_REN(CHNL_RX_DATA_REN)
  );

  logic [DATA_W-1:0] ram [0:1023];
  always @(posedge clk_pcie) if (src_rd) src_data <= ram[src_addr[9:0]];

  localparam logic [DATA_W-1:0] CFG_BASIC = 128'h0000_0010_0000_0004_0000_0007_0000_0123;

  int vec_cnt = 0;
  int err_cnt = 0;
  logic [DATA_W-1:0] got [$];
  int hold_err, bubbles, req_bad, early_valid, max_addr, done_early, rx_bad, fin_ok, timeout;

  // Plays one frame from the receiver side and records what it saw; the test tasks judge it.
  task automatic run_frame(input int ren_mode, input int ack_dly, input int abort_after,
                           input bit restart_in_req, input logic [31:0] exp_len);
    logic [DATA_W-1:0] prev_data;
    bit prev_hold;
    int exp_w;
    got.delete();
    hold_err = 0; bubbles = 0; req_bad = 0; early_valid = 0; max_addr = 0;
    done_early = 0; rx_bad = 0; fin_ok = 0; timeout = 0;
    exp_w = int'(exp_len / 4);
    prev_hold = 1'b0;
    prev_data = '0;
    @(posedge clk_pcie); #1; start = 1'b1;
    @(posedge clk_pcie); #1; start = 1'b0;
    for (int i = 0; i < ack_dly; i++) begin
      if (restart_in_req && i == 0) begin start = 1'b1; sys_words = 32'd8; end
      else start = 1'b0;
      if (CHNL_RX !== 1'b1 || CHNL_RX_LEN !== exp_len || busy !== 1'b1) req_bad++;
      if (CHNL_RX_DATA_VALID !== 1'b0) early_valid++;
      if (int'(src_addr) > max_addr) max_addr = int'(src_addr);
      @(posedge clk_pcie); #1;
    end
    start = 1'b0;
    if (CHNL_RX !== 1'b1 || CHNL_RX_LEN !== exp_len) req_bad++;
    if (CHNL_RX_DATA_VALID !== 1'b0) early_valid++;
    CHNL_RX_ACK = 1'b1;
    @(posedge clk_pcie); #1;
    CHNL_RX_ACK = 1'b0;
    for (int cyc = 0; cyc < 4000; cyc++) begin
      if (int'(src_addr) > max_addr) max_addr = int'(src_addr);
      if (done !== 1'b0) done_early++;
      if (CHNL_RX !== 1'b1) rx_bad++;
      if (prev_hold && (CHNL_RX_DATA_VALID !== 1'b1 || CHNL_RX_DATA !== prev_data)) hold_err++;
      if (ren_mode == 0 && got.size() > 0 && CHNL_RX_DATA_VALID !== 1'b1) bubbles++;
      if (abort_after != 0 && got.size() == abort_after) begin
        CHNL_RX_DATA_REN = 1'b0;
        return;
      end
      case (ren_mode)
        0: CHNL_RX_DATA_REN = 1'b1;
        1: CHNL_RX_DATA_REN = (cyc % 2 == 0);
        default: CHNL_RX_DATA_REN = 1'($urandom_range(0, 1));
      endcase
      prev_hold = CHNL_RX_DATA_VALID && !CHNL_RX_DATA_REN;
      prev_data = CHNL_RX_DATA;
      if (CHNL_RX_DATA_VALID === 1'b1 && CHNL_RX_DATA_REN) got.push_back(CHNL_RX_DATA);
      @(posedge clk_pcie); #1;
      if (got.size() == exp_w) break;
    end
    CHNL_RX_DATA_REN = 1'b0;
    if (got.size() != exp_w) timeout = 1;
    fin_ok = (done === 1'b1 && CHNL_RX === 1'b0 && CHNL_RX_DATA_VALID === 1'b0 && busy === 1'b0);
    @(posedge clk_pcie); #1;
    if (done !== 1'b0) fin_ok = 0;
  endtask

  task automatic test_reset();
    RST = 1'b1;
    repeat (3) @(posedge clk_pcie);
    #1;
    vec_cnt++; if (busy !== 1'b0) begin err_cnt++; $display("FAIL reset_busy got %0b want 0", busy); end
    vec_cnt++; if (done !== 1'b0) begin err_cnt++; $display("FAIL reset_done got %0b want 0", done); end
    vec_cnt++; if (CHNL_RX !== 1'b0 || CHNL_RX_DATA_VALID !== 1'b0 || src_rd !== 1'b0) begin
      err_cnt++; $display("FAIL reset_ctl got rx=%0b valid=%0b rd=%0b want 0 0 0", CHNL_RX, CHNL_RX_DATA_VALID, src_rd); end
    vec_cnt++; if (CHNL_RX_LEN !== 32'd0 || CHNL_RX_DATA !== '0 || src_addr !== '0) begin
      err_cnt++; $display("FAIL reset_data got len=%0h data=%0h addr=%0h want 0", CHNL_RX_LEN, CHNL_RX_DATA, src_addr); end
    vec_cnt++; if (CHNL_RX_LAST !== 1'b1 || CHNL_RX_OFF !== 31'd0) begin
      err_cnt++; $display("FAIL reset_const got last=%0b off=%0h want 1 0", CHNL_RX_LAST, CHNL_RX_OFF); end
    RST = 1'b0;
    $display("test_reset done: %0d vectors so far", vec_cnt);
  endtask

  task automatic test_basic();
    int bad = 0;
    run_frame(0, 1, 0, 1'b0, 32'd60);
    for (int i = 1; i < got.size(); i++) if (got[i] !== ram[i-1]) bad++;
    vec_cnt++; if (timeout != 0 || got.size() != 15) begin err_cnt++; $display("FAIL basic_count got %0d want 15", got.size()); end
    vec_cnt++; if (got.size() == 0 || got[0] !== CFG_BASIC) begin err_cnt++; $display("FAIL basic_cfg got %0h want %0h", (got.size() > 0) ? got[0] : '0, CFG_BASIC); end
    vec_cnt++; if (bad != 0) begin err_cnt++; $display("FAIL basic_order got %0d bad words want 0", bad); end
    vec_cnt++; if (bubbles != 0 || rx_bad != 0) begin err_cnt++; $display("FAIL basic_stream got bubbles=%0d rxdrop=%0d want 0 0", bubbles, rx_bad); end
    vec_cnt++; if (req_bad != 0 || early_valid != 0) begin err_cnt++; $display("FAIL basic_req got req_bad=%0d early=%0d want 0 0", req_bad, early_valid); end
    vec_cnt++; if (fin_ok != 1 || done_early != 0) begin err_cnt++; $display("FAIL basic_done got fin=%0d early=%0d want 1 0", fin_ok, done_early); end
    vec_cnt++; if (max_addr > 13) begin err_cnt++; $display("FAIL basic_addr got %0d want <=13", max_addr); end
    $display("test_basic done: %0d words received", got.size());
  endtask

  task automatic test_backpressure();
    for (int mode = 1; mode <= 2; mode++) begin
      int bad = 0;
      run_frame(mode, 1, 0, 1'b0, 32'd60);
      for (int i = 1; i < got.size(); i++) if (got[i] !== ram[i-1]) bad++;
      if (got.size() == 0 || got[0] !== CFG_BASIC) bad++;
      vec_cnt++; if (timeout != 0 || got.size() != 15 || bad != 0) begin
        err_cnt++; $display("FAIL bp_seq mode %0d got %0d words %0d bad want 15 0", mode, got.size(), bad); end
      vec_cnt++; if (hold_err != 0) begin err_cnt++; $display("FAIL bp_hold mode %0d got %0d unstable want 0", mode, hold_err); end
      vec_cnt++; if (fin_ok != 1 || done_early != 0) begin err_cnt++; $display("FAIL bp_done mode %0d got fin=%0d want 1", mode, fin_ok); end
      $display("test_backpressure mode %0d done: %0d words", mode, got.size());
    end
  endtask

  task automatic test_ack_delay();
    int bad = 0;
    run_frame(0, 10, 0, 1'b0, 32'd60);
    for (int i = 1; i < got.size(); i++) if (got[i] !== ram[i-1]) bad++;
    vec_cnt++; if (req_bad != 0) begin err_cnt++; $display("FAIL ackdly_req got %0d unstable cycles want 0", req_bad); end
    vec_cnt++; if (early_valid != 0) begin err_cnt++; $display("FAIL ackdly_valid got %0d early cycles want 0", early_valid); end
    vec_cnt++; if (max_addr > 13) begin err_cnt++; $display("FAIL ackdly_addr got %0d want <=13", max_addr); end
    vec_cnt++; if (timeout != 0 || got.size() != 15 || bad != 0) begin err_cnt++; $display("FAIL ackdly_seq got %0d words %0d bad want 15 0", got.size(), bad); end
    $display("test_ack_delay done: %0d words", got.size());
  endtask

  task automatic test_large();
    int bad = 0;
    sys_words = 32'd160; cb_num = 5'd3; tx_words = 32'hDEAD_BEEF;
    run_frame(0, 1, 0, 1'b0, 32'd1380);
    for (int i = 1; i < got.size(); i++) if (got[i] !== ram[i-1]) bad++;
    vec_cnt++; if (timeout != 0 || got.size() != 345) begin err_cnt++; $display("FAIL large_count got %0d want 345", got.size()); end
    vec_cnt++; if (got.size() == 0 || got[0][95:64] !== 32'd160 || got[0][127:96] !== 32'hDEAD_BEEF) begin
      err_cnt++; $display("FAIL large_cfg got %0h want sys=a0 tx=deadbeef", (got.size() > 0) ? got[0] : '0); end
    vec_cnt++; if (got.size() != 345 || got[344] !== ram[343]) begin err_cnt++; $display("FAIL large_last got %0h want %0h", (got.size() == 345) ? got[344] : '0, ram[343]); end
    vec_cnt++; if (bad != 0 || bubbles != 0) begin err_cnt++; $display("FAIL large_stream got bad=%0d bubbles=%0d want 0 0", bad, bubbles); end
    vec_cnt++; if (max_addr > 343 || fin_ok != 1) begin err_cnt++; $display("FAIL large_end got addr=%0d fin=%0d want <=343 1", max_addr, fin_ok); end
    sys_words = 32'd4; cb_num = 5'd0; tx_words = 32'h10;
    $display("test_large done: %0d words", got.size());
  endtask

  task automatic test_reset_mid();
    int dones = 0;
    int bad = 0;
    run_frame(0, 1, 7, 1'b0, 32'd60);
    vec_cnt++; if (got.size() != 7) begin err_cnt++; $display("FAIL abort_count got %0d want 7", got.size()); end
    RST = 1'b1;
    @(posedge clk_pcie); #1;
    vec_cnt++; if (busy !== 1'b0 || done !== 1'b0 || CHNL_RX !== 1'b0 || CHNL_RX_DATA_VALID !== 1'b0 || src_rd !== 1'b0) begin
      err_cnt++; $display("FAIL abort_ctl got busy=%0b done=%0b rx=%0b valid=%0b rd=%0b want 0", busy, done, CHNL_RX, CHNL_RX_DATA_VALID, src_rd); end
    vec_cnt++; if (CHNL_RX_LEN !== 32'd0 || CHNL_RX_DATA !== '0 || src_addr !== '0) begin
      err_cnt++; $display("FAIL abort_data got len=%0h data=%0h addr=%0h want 0", CHNL_RX_LEN, CHNL_RX_DATA, src_addr); end
    RST = 1'b0;
    for (int i = 0; i < 5; i++) begin
      if (done !== 1'b0 || busy !== 1'b0) dones++;
      @(posedge clk_pcie); #1;
    end
    vec_cnt++; if (dones != 0) begin err_cnt++; $display("FAIL abort_nodone got %0d active cycles want 0", dones); end
    run_frame(0, 1, 0, 1'b0, 32'd60);
    for (int i = 1; i < got.size(); i++) if (got[i] !== ram[i-1]) bad++;
    if (got.size() == 0 || got[0] !== CFG_BASIC) bad++;
    vec_cnt++; if (timeout != 0 || got.size() != 15 || bad != 0 || fin_ok != 1) begin
      err_cnt++; $display("FAIL abort_restart got %0d words %0d bad fin=%0d want 15 0 1", got.size(), bad, fin_ok); end
    $display("test_reset_mid done: restart frame %0d words", got.size());
  endtask

  task automatic test_ignored_start();
    int act = 0;
    int bad = 0;
    sys_words = 32'd0;
    @(posedge clk_pcie); #1; start = 1'b1;
    @(posedge clk_pcie); #1; start = 1'b0;
    for (int i = 0; i < 4; i++) begin
      if (CHNL_RX !== 1'b0 || busy !== 1'b0) act++;
      @(posedge clk_pcie); #1;
    end
    vec_cnt++; if (act != 0) begin err_cnt++; $display("FAIL zero_sys got %0d active cycles want 0", act); end
    sys_words = 32'd4;
    run_frame(0, 3, 0, 1'b1, 32'd60);
    sys_words = 32'd4;
    for (int i = 1; i < got.size(); i++) if (got[i] !== ram[i-1]) bad++;
    vec_cnt++; if (req_bad != 0) begin err_cnt++; $display("FAIL busy_start got %0d disturbed REQ cycles want 0", req_bad); end
    vec_cnt++; if (timeout != 0 || got.size() != 15 || bad != 0) begin err_cnt++; $display("FAIL busy_seq got %0d words %0d bad want 15 0", got.size(), bad); end
    act = 0;
    for (int i = 0; i < 3; i++) begin
      if (CHNL_RX !== 1'b0 || busy !== 1'b0) act++;
      @(posedge clk_pcie); #1;
    end
    vec_cnt++; if (act != 0) begin err_cnt++; $display("FAIL busy_after got %0d active cycles want 0", act); end
    $display("test_ignored_start done");
  endtask

  initial begin
    for (int k = 0; k < 1024; k++) begin
      logic [31:0] kk;
      kk = k;
      ram[k] = {32'hC0DE_0000 + kk, ~kk, kk * 32'h9E37_79B9, kk};
    end
    RST = 1'b1; start = 1'b0; CHNL_RX_ACK = 1'b0; CHNL_RX_DATA_REN = 1'b0;
    code_length = 13'h123; iter_max = 4'h7; sys_words = 32'd4; tx_words = 32'h10; cb_num = 5'd0;
    test_reset();
    test_basic();
    test_backpressure();
    test_ack_delay();
    test_large();
    test_reset_mid();
    test_ignored_start();
    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
